// File: rtl/midi_pkg.sv
// midi_pkg: constants and state types shared by the MIDI input front end.
//   - status nibble constants for the channel voice types the parser cares about
//   - byte classification thresholds (real-time, system common)
//   - UART receiver and message parser state enums
//   - one_data_byte(): voice types that carry a single data byte
`timescale 1ns/1ps
package midi_pkg;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] PROG_CHG   = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;

    // 0xF8..0xFF are real-time, 0xF0..0xF7 system common / SysEx
    localparam logic [7:0] RT_THRESHOLD  = 8'hF8;
    localparam logic [7:0] SYS_THRESHOLD = 8'hF0;

    typedef enum logic [1:0] {
        WAIT_STATUS,
        WAIT_D1,
        WAIT_D2
    } parser_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    function automatic logic one_data_byte(input logic [3:0] kind);
        return (kind == PROG_CHG) || (kind == CHAN_PRESS);
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 serial receiver for the MIDI input pin.
// Ports:
//   clk, reset_n   system clock, synchronous active-low reset
//   i_midi_rx      raw asynchronous serial line, idles high
//   o_byte         received byte, valid while o_byte_valid is high
//   o_byte_valid   one-cycle strobe, one cycle after a good stop-bit sample
//   o_frame_err    one-cycle strobe, one cycle after a low stop-bit sample
// Handshake: o_byte_valid / o_frame_err are single-cycle strobes with no
// ready; the consumer must accept on the cycle they are high.
// The receiver state is held in rx_state (rx_state_t).
`timescale 1ns/1ps
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_midi_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta, rx_sync, rx_prev;
    rx_state_t     rx_state, rx_state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shreg, shreg_next;
    logic          byte_valid_next, frame_err_next;

    // The shift register holds the last byte from the final data sample
    // until the next frame's first data sample, so it covers the strobe.
    assign o_byte = shreg;

    always_comb begin
        rx_state_next   = rx_state;
        cnt_next        = cnt + 1'b1;
        bit_idx_next    = bit_idx;
        shreg_next      = shreg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                // Counter restarts on every start bit, so no drift carries over.
                cnt_next = '0;
                if (rx_prev && !rx_sync) rx_state_next = RX_START;
            end
            RX_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next      = '0;
                    bit_idx_next  = '0;
                    // Line back high at mid start bit: a glitch, not a frame.
                    rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_sync, shreg[7:1]};
                    if (bit_idx == 3'd7) rx_state_next = RX_STOP;
                    else                 bit_idx_next  = bit_idx + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_sync) begin
                        byte_valid_next = 1'b1;
                        rx_state_next   = RX_IDLE;
                    end else begin
                        frame_err_next  = 1'b1;
                        rx_state_next   = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_sync) rx_state_next = RX_IDLE;
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            rx_meta      <= i_midi_rx;
            rx_sync      <= rx_meta;
            rx_prev      <= rx_sync;
            rx_state     <= rx_state_next;
            cnt          <= cnt_next;
            bit_idx      <= bit_idx_next;
            shreg        <= shreg_next;
            o_byte_valid <= byte_valid_next;
            o_frame_err  <= frame_err_next;
        end
    end

endmodule

// File: rtl/midi_note_decoder.sv
// midi_note_decoder: MIDI serial input to monophonic, last-note-priority note.
// Ports:
//   clk, reset_n    system clock, synchronous active-low reset
//   i_midi_rx       raw MIDI serial input (asynchronous, idles high)
//   o_midi          current note, 0 = silence (feeds phase_bank.i_midi)
//   o_velocity      velocity of the current note, 0 whenever o_midi is 0
//   o_note_strobe   one-cycle pulse when o_midi changes value
//   o_frame_err     one-cycle pulse on a bad stop bit
// Parameters: CLK_HZ, BAUD set the bit period; CHANNEL 0..15, 16 = omni.
// The parser state is held in parser_state (parser_state_t); running status
// is valid exactly when parser_state is not WAIT_STATUS.
`timescale 1ns/1ps
module midi_note_decoder
    import midi_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 31250,
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_midi_rx,
    output logic [6:0] o_midi,
    output logic [6:0] o_velocity,
    output logic       o_note_strobe,
    output logic       o_frame_err
);

    localparam int         CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam bit         OMNI         = (CHANNEL == 16);
    localparam logic [3:0] CHAN         = 4'(CHANNEL);

    logic [7:0]    rx_byte;
    logic          rx_valid;

    parser_state_t parser_state, parser_state_next;
    logic [7:0]    rs, rs_next;
    logic [6:0]    d1, d1_next;
    logic [6:0]    midi_next, vel_next;
    logic          msg_done;
    logic [3:0]    kind;
    logic          chan_ok;

    midi_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_midi_rx    (i_midi_rx),
        .o_byte       (rx_byte),
        .o_byte_valid (rx_valid),
        .o_frame_err  (o_frame_err)
    );

    assign kind    = rs[7:4];
    assign chan_ok = OMNI || (rs[3:0] == CHAN);

    always_comb begin
        parser_state_next = parser_state;
        rs_next           = rs;
        d1_next           = d1;
        midi_next         = o_midi;
        vel_next          = o_velocity;
        msg_done          = 1'b0;

        if (o_frame_err) begin
            // Restart the data index; running status survives.
            if (parser_state != WAIT_STATUS) parser_state_next = WAIT_D1;
        end else if (rx_valid) begin
            if (rx_byte >= RT_THRESHOLD) begin
                // Real-time bytes pass through without touching the parser.
                parser_state_next = parser_state;
            end else if (rx_byte >= SYS_THRESHOLD) begin
                rs_next           = '0;
                parser_state_next = WAIT_STATUS;
            end else if (rx_byte[7]) begin
                rs_next           = rx_byte;
                parser_state_next = WAIT_D1;
            end else begin
                case (parser_state)
                    WAIT_D1: begin
                        // Single-data-byte messages complete here; none of
                        // them affects the note, so they need no action.
                        if (!one_data_byte(kind)) begin
                            d1_next           = rx_byte[6:0];
                            parser_state_next = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        msg_done          = 1'b1;
                        parser_state_next = WAIT_D1;
                    end
                    default: parser_state_next = WAIT_STATUS;
                endcase
            end
        end

        if (msg_done && chan_ok) begin
            if (kind == NOTE_ON && d1 != '0 && rx_byte[6:0] != '0) begin
                midi_next = d1;
                vel_next  = rx_byte[6:0];
            end else if ((kind == NOTE_OFF || kind == NOTE_ON) && d1 == o_midi) begin
                midi_next = '0;
                vel_next  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            parser_state  <= WAIT_STATUS;
            rs            <= '0;
            d1            <= '0;
            o_midi        <= '0;
            o_velocity    <= '0;
            o_note_strobe <= 1'b0;
        end else begin
            parser_state  <= parser_state_next;
            rs            <= rs_next;
            d1            <= d1_next;
            o_midi        <= midi_next;
            o_velocity    <= vel_next;
            // A velocity-only update on the same note does not strobe.
            o_note_strobe <= (midi_next != o_midi);
        end
    end

endmodule

// File: tb/tb_midi_note_decoder.sv
`timescale 1ns/1ps
module tb_midi_note_decoder;

  // Short bit period keeps the run small; the design only sees CLKS_PER_BIT.
  localparam int CLK_HZ = 640_000;
  localparam int BAUD   = 20_000;
  localparam int CPB    = CLK_HZ / BAUD;  // 32
  localparam int HALF   = CPB / 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;
  always #5 clk = ~clk;

  logic [6:0] o_midi, o_velocity, o_midi_o, o_velocity_o;
  logic       o_note_strobe, o_frame_err, o_note_strobe_o, o_frame_err_o;

  midi_note_decoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(0)) dut (
    .clk(clk), .reset_n(reset_n), .i_midi_rx(rx),
    .o_midi(o_midi), .o_velocity(o_velocity),
    .o_note_strobe(o_note_strobe), .o_frame_err(o_frame_err));

  midi_note_decoder #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(16)) dut_omni (
    .clk(clk), .reset_n(reset_n), .i_midi_rx(rx),
    .o_midi(o_midi_o), .o_velocity(o_velocity_o),
    .o_note_strobe(o_note_strobe_o), .o_frame_err(o_frame_err_o));

  // ---------------- reference model ----------------
  typedef struct {
    int         rs;     // running status byte, -1 when none
    int         nd;     // data bytes collected for the current message
    logic [6:0] d1;
    logic [6:0] midi;
    logic [6:0] vel;
  } model_t;

  model_t m0, mo;

  function automatic model_t model_init();
    model_t m;
    m.rs = -1; m.nd = 0; m.d1 = '0; m.midi = '0; m.vel = '0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m_in, logic [7:0] b, int chan);
    model_t m;
    int kind, ch, need, note, vel;
    m = m_in;
    if (b >= 8'hF8) return m;
    if (b >= 8'hF0) begin m.rs = -1; m.nd = 0; return m; end
    if (b >= 8'h80) begin m.rs = int'(b); m.nd = 0; return m; end
    if (m.rs < 0) return m;
    kind = m.rs / 16;
    ch   = m.rs % 16;
    need = (kind == 12 || kind == 13) ? 1 : 2;
    if (m.nd == 0) m.d1 = b[6:0];
    m.nd++;
    if (m.nd < need) return m;
    m.nd = 0;
    if (!(chan == 16 || ch == chan) || need == 1) return m;
    note = int'(m.d1);
    vel  = int'(b);
    if (kind == 9 && note != 0 && vel != 0) begin
      m.midi = 7'(note); m.vel = 7'(vel);
    end else if ((kind == 8 || kind == 9) && note == int'(m.midi)) begin
      m.midi = '0; m.vel = '0;
    end
    return m;
  endfunction

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];
  logic [6:0] exp_qo[$];
  int checks = 0;
  int errors = 0;
  int ferr_seen = 0;
  int ferr_exp = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (reset_n) begin
      if (o_frame_err) ferr_seen++;
      if (o_note_strobe) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL strobe_unexpected: o_midi=0x%0h, no change expected", o_midi);
        end else check("strobe_note", o_midi, exp_q.pop_front());
        if (o_midi == 7'd0) check("silence_velocity", o_velocity, 0);
      end
      if (o_note_strobe_o) begin
        if (exp_qo.size() == 0) begin
          checks++; errors++;
          $display("FAIL omni_strobe_unexpected: o_midi=0x%0h, no change expected", o_midi_o);
        end else check("omni_strobe_note", o_midi_o, exp_qo.pop_front());
        if (o_midi_o == 7'd0) check("omni_silence_velocity", o_velocity_o, 0);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at a negedge. No idle after a good stop
  // bit, so consecutive calls are back-to-back frames.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    logic [6:0] p0, po;
    p0 = m0.midi;
    po = mo.midi;
    if (stop_ok) begin
      m0 = model_step(m0, b, 0);
      mo = model_step(mo, b, 16);
    end else begin
      m0.nd = 0;
      mo.nd = 0;
      ferr_exp++;
    end
    if (m0.midi != p0) exp_q.push_back(m0.midi);
    if (mo.midi != po) exp_qo.push_back(mo.midi);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [5:0][7:0] b;
    int              n;
    logic [6:0]      midi;
    logic [6:0]      vel;
    logic [6:0]      omidi;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [7:0] b0, b1, b2, b3, b4, b5, input int n,
                         input logic [6:0] midi, vel, omidi);
    vec_t v;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
    v.n = n; v.midi = midi; v.vel = vel; v.omidi = omidi;
    vq.push_back(v);
  endtask

  task automatic sb_drained(input string tag);
    check({tag, "_exp_q_empty"}, exp_q.size(), 0);
    check({tag, "_exp_qo_empty"}, exp_qo.size(), 0);
  endtask

  initial begin
    int cyc;
    bit seen;
    bit in_win;
    logic [7:0] rb;
    int r;

    m0 = model_init();
    mo = model_init();

    // stream                                  n   midi   vel    omni
    add_vec(8'h90, 8'h45, 8'h64, 0, 0, 0,      3, 7'h45, 7'h64, 7'h45);
    add_vec(8'h48, 8'h50, 0, 0, 0, 0,          2, 7'h48, 7'h50, 7'h48);
    add_vec(8'h80, 8'h45, 8'h00, 0, 0, 0,      3, 7'h48, 7'h50, 7'h48);
    add_vec(8'h48, 8'h00, 0, 0, 0, 0,          2, 7'h00, 7'h00, 7'h00);
    add_vec(8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h40, 0, 5, 7'h3C, 7'h40, 7'h3C);
    add_vec(8'hF0, 8'h3C, 8'h40, 0, 0, 0,      3, 7'h3C, 7'h40, 7'h3C);
    add_vec(8'h3E, 8'h40, 0, 0, 0, 0,          2, 7'h3C, 7'h40, 7'h3C);
    add_vec(8'h91, 8'h3D, 8'h41, 0, 0, 0,      3, 7'h3C, 7'h40, 7'h3D);
    add_vec(8'hC0, 8'h05, 8'h90, 8'h3E, 8'h41, 0, 5, 7'h3E, 7'h41, 7'h3E);
    add_vec(8'h90, 8'h00, 8'h40, 0, 0, 0,      3, 7'h3E, 7'h41, 7'h3E);
    add_vec(8'h3E, 8'h22, 0, 0, 0, 0,          2, 7'h3E, 7'h22, 7'h3E);
    add_vec(8'hD0, 8'h10, 8'h90, 8'h3E, 8'h00, 0, 5, 7'h00, 7'h00, 7'h00);
    add_vec(8'hC0, 8'h05, 8'h06, 8'h90, 8'h50, 8'h60, 6, 7'h50, 7'h60, 7'h50);

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_midi", o_midi, 0);
    check("reset_velocity", o_velocity, 0);
    check("reset_strobe", o_note_strobe, 0);
    check("reset_frame_err", o_frame_err, 0);
    check("reset_omni_midi", o_midi_o, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // table-driven vectors (state carries from one to the next)
    for (int k = 0; k < vq.size(); k++) begin
      for (int j = 0; j < vq[k].n; j++) send_byte(vq[k].b[j], 1'b1);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_midi", k), o_midi, vq[k].midi);
      check($sformatf("vec%0d_velocity", k), o_velocity, vq[k].vel);
      check($sformatf("vec%0d_omni_midi", k), o_midi_o, vq[k].omidi);
      sb_drained($sformatf("vec%0d", k));
    end

    // frame error: byte dropped, next clean message decodes
    send_byte(8'h55, 1'b0);
    check("ferr_count_1", ferr_seen, 1);
    send_byte(8'h90, 1'b1); send_byte(8'h30, 1'b1); send_byte(8'h40, 1'b1);
    repeat (4) @(negedge clk);
    check("after_ferr_midi", o_midi, 7'h30);
    // frame error inside a message restarts the data index
    send_byte(8'h31, 1'b1); send_byte(8'h77, 1'b0);
    send_byte(8'h32, 1'b1); send_byte(8'h44, 1'b1);
    repeat (4) @(negedge clk);
    check("ferr_index_midi", o_midi, 7'h32);
    check("ferr_index_velocity", o_velocity, 7'h44);
    check("ferr_count_2", ferr_seen, 2);

    // short low glitch, then a real frame one bit time after it
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (CPB - 4) @(negedge clk);
    send_byte(8'h33, 1'b1); send_byte(8'h46, 1'b1);
    repeat (4) @(negedge clk);
    check("glitch_midi", o_midi, 7'h33);
    check("glitch_velocity", o_velocity, 7'h46);
    check("glitch_no_ferr", ferr_seen, 2);

    // latency: start-bit fall of the last byte to the note strobe
    send_byte(8'h90, 1'b1); send_byte(8'h52, 1'b1);
    cyc = 0; seen = 1'b0;
    fork
      send_byte(8'h70, 1'b1);
      begin
        while (cyc < 12 * CPB && !seen) begin
          @(posedge clk); cyc++; #1;
          if (o_note_strobe) seen = 1'b1;
        end
      end
    join
    in_win = seen && cyc >= HALF + 9 * CPB + 2 && cyc <= HALF + 9 * CPB + 6;
    checks++;
    if (!in_win) begin
      errors++;
      $display("FAIL latency: strobe seen=%0d after %0d cycles, expected %0d..%0d",
               seen, cyc, HALF + 9 * CPB + 2, HALF + 9 * CPB + 6);
    end
    check("latency_midi", o_midi, 7'h52);

    // reset during the data bits of the second byte
    send_byte(8'h90, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b0;
    repeat (HALF) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_midi", o_midi, 0);
    check("midreset_velocity", o_velocity, 0);
    check("midreset_omni_midi", o_midi_o, 0);
    @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    m0 = model_init();
    mo = model_init();
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h90, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h7F, 1'b1);
    repeat (4) @(negedge clk);
    check("postreset_midi", o_midi, 7'h40);
    check("postreset_velocity", o_velocity, 7'h7F);
    sb_drained("postreset");

    // randomized stream against the model
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 99);
      if (r < 25) begin
        case ($urandom_range(0, 5))
          0: rb = 8'h80; 1: rb = 8'h90; 2: rb = 8'h91;
          3: rb = 8'hC0; 4: rb = 8'hD1; default: rb = 8'hB0;
        endcase
      end else if (r < 30) rb = 8'hF8 + 8'($urandom_range(0, 7));
      else if (r < 32) rb = 8'hF0;
      else rb = 8'($urandom_range(0, 4));
      send_byte(rb, ($urandom_range(0, 24) != 0));
      if (n % 30 == 29) begin
        repeat (4) @(negedge clk);
        check($sformatf("rand%0d_midi", n), o_midi, m0.midi);
        check($sformatf("rand%0d_velocity", n), o_velocity, m0.vel);
        check($sformatf("rand%0d_omni_midi", n), o_midi_o, mo.midi);
        check($sformatf("rand%0d_omni_velocity", n), o_velocity_o, mo.vel);
      end
    end
    repeat (4) @(negedge clk);
    sb_drained("rand_end");
    check("rand_ferr_count", ferr_seen, ferr_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (150_000) @(posedge clk);
    checks++;
    errors++;
    $display("FAIL watchdog: run did not complete within 150000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
